instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 12 +
 rtl/instr_fetch_unit_pc_reg.sv | 26 ++
 rtl/instr_fetch_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package instr_fetch_unit_pkg;
  typedef enum logic {FETCH = 1'b0, BR_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {PC_HOLD = 2'd0, PC_INC = 2'd1, PC_LOAD = 2'd2} pc_sel_t;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with hold / increment / load-target select.
module pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_t     sel,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + 32'd4;
        PC_LOAD: pc <= target;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the PC to instruction memory and fills the IF/ID register,
// inserting bubbles while a detected branch waits for resolution in EX.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Br_Dectected,
  input  logic        Br_Resolved,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] Inst,
  output logic [31:0] Inst_PC,
  output logic        Inst_Valid,
  output logic [15:0] Bubble_Cnt
);

  state_t      state;
  pc_sel_t     pc_sel;
  logic [31:0] pc;
  logic        detect;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Only a real instruction in IF/ID can open a branch window.
  assign detect    = Br_Dectected && Inst_Valid;
  assign Imem_Addr = pc;

  always_comb begin
    pc_sel = PC_HOLD;
    case (state)
      FETCH:   if (!Stall && !detect) pc_sel = PC_INC;
      BR_WAIT: if (Br_Resolved && Br_Taken) pc_sel = PC_LOAD;
      default: pc_sel = PC_HOLD;
    endcase
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (align_word(Br_Target)),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      Inst       <= NOP_INST;
      Inst_PC    <= RESET_PC;
      Inst_Valid <= 1'b0;
      Bubble_Cnt <= 16'd0;
    end else begin
      case (state)
        FETCH: begin
          if (Stall) begin
            state <= FETCH;
          end else if (detect) begin
            Inst       <= NOP_INST;
            Inst_Valid <= 1'b0;
            Bubble_Cnt <= sat_inc(Bubble_Cnt);
            state      <= BR_WAIT;
          end else begin
            Inst       <= Imem_Data;
            Inst_PC    <= pc;
            Inst_Valid <= 1'b1;
          end
        end
        BR_WAIT: begin
          Inst       <= NOP_INST;
          Inst_Valid <= 1'b0;
          Bubble_Cnt <= sat_inc(Bubble_Cnt);
          if (Br_Resolved) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
